// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, RV32
// funct3 size/sign codes, the decoded access size, and small decode helpers
// used by both the FSM (lsu) and the lane datapath (lsu_align).
// ----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_RWAIT = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Bit 2 only carries signedness, so the size comes from bits [1:0];
    // the reserved codes 011/110/111 therefore fall through to word.
    function automatic size_t decodeSize(input logic [2:0] f3);
        size_t sz;
        case ({1'b0, f3[1:0]})
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_W:    sz = SZ_W;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic isUnsignedLoad(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic isMisaligned(input size_t sz, input logic [1:0] lane);
        logic mis;
        case (sz)
            SZ_H:    mis = lane[0];
            SZ_W:    mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane datapath for the load/store unit.
//   i_size      : decoded access size (byte / half / word)
//   i_unsigned  : zero-extend loads instead of sign-extending
//   i_lane      : byte offset within the word (addr[1:0])
//   i_rdata     : word read from memory
//   i_wdata     : store data from the requester (low bits for sub-word)
//   o_load_data : selected lane, extended to 32 bits
//   o_merged    : read word with the addressed lane replaced by store data
// Halfword lanes use only lane[1], so an odd half address is naturally
// force-aligned when misalignment trapping is not built in.
// ----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  size_t       i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_lane)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_load_data = i_rdata;
        case (i_size)
            SZ_B:    o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_H:    o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

    always_comb begin
        o_merged = i_wdata;
        case (i_size)
            SZ_B: begin
                o_merged = i_rdata;
                case (i_lane)
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    2'd3:    o_merged[31:24] = i_wdata[7:0];
                    default: o_merged[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_H: begin
                o_merged = i_rdata;
                if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
                else           o_merged[15:0]  = i_wdata[15:0];
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu
// Load/store unit: accepts one RV32 load or store from the memory stage and
// drives a word-wide, 1-cycle-latency data memory with no byte enables.
// Sub-word stores are done as read-modify-write.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready, i_req_store, i_req_funct3, i_req_addr,
//   i_req_wdata         : request handshake and fields
//   o_resp_valid, o_resp_rdata, o_resp_misaligned : one-cycle completion
//   o_mem_addr, o_mem_rd_en, o_mem_wr_en, o_mem_wdata, i_mem_rdata :
//                         data memory port
// Build option: LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
// accesses are suppressed and reported; otherwise they are force-aligned.
// ----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_store,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_misaligned,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_rd_en,
    output logic        o_mem_wr_en,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    state_t      r_state;
    logic        r_store;
    size_t       r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_misaligned;
    logic [31:0] r_mem_addr;
    logic        r_mem_rd_en;
    logic        r_mem_wr_en;
    logic [31:0] r_mem_wdata;

    size_t       w_req_size;
    logic        w_misaligned;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_req_size = decodeSize(i_req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misaligned = isMisaligned(w_req_size, i_req_addr[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    lsu_align u_align (
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_lane      (r_lane),
        .i_rdata     (i_mem_rdata),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    // Strobes and resp_valid default low each cycle so they are only high
    // in the single state that sets them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state           <= S_IDLE;
            r_store           <= 1'b0;
            r_size            <= SZ_B;
            r_unsigned        <= 1'b0;
            r_lane            <= 2'b00;
            r_wdata           <= 32'h0;
            r_resp_valid      <= 1'b0;
            r_resp_rdata      <= 32'h0;
            r_resp_misaligned <= 1'b0;
            r_mem_addr        <= 32'h0;
            r_mem_rd_en       <= 1'b0;
            r_mem_wr_en       <= 1'b0;
            r_mem_wdata       <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            r_mem_rd_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_store           <= i_req_store;
                        r_size            <= w_req_size;
                        r_unsigned        <= isUnsignedLoad(i_req_funct3);
                        r_lane            <= i_req_addr[1:0];
                        r_wdata           <= i_req_wdata;
                        r_mem_addr        <= {i_req_addr[31:2], 2'b00};
                        r_resp_rdata      <= 32'h0;
                        r_resp_misaligned <= w_misaligned;
                        if (w_misaligned) begin
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else if (i_req_store && (w_req_size == SZ_W)) begin
                            r_mem_wdata <= i_req_wdata;
                            r_mem_wr_en <= 1'b1;
                            r_state     <= S_WRITE;
                        end else begin
                            r_mem_rd_en <= 1'b1;
                            r_state     <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_RWAIT;
                end
                S_RWAIT: begin
                    if (r_store) begin
                        r_mem_wdata <= w_merged;
                        r_mem_wr_en <= 1'b1;
                        r_state     <= S_WRITE;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_resp_misaligned <= 1'b0;
                    r_state           <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready       = (r_state == S_IDLE);
    assign o_resp_valid      = r_resp_valid;
    assign o_resp_rdata      = r_resp_rdata;
    assign o_resp_misaligned = r_resp_misaligned;
    assign o_mem_addr        = r_mem_addr;
    assign o_mem_rd_en       = r_mem_rd_en;
    assign o_mem_wr_en       = r_mem_wr_en;
    assign o_mem_wdata       = r_mem_wdata;

endmodule

// File: tb/tb_lsu.sv
// ----------------------------------------------------------------------------
// tb_lsu
// Self-checking bench for lsu: a word-array memory with 1-cycle read
// latency, a byte-lane reference model written with shifts and masks, and
// directed plus randomized transactions. Honours LSU_MISALIGN_TRAP_EN.
// ----------------------------------------------------------------------------
module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_store = 1'b0;
    logic [2:0]  i_req_funct3 = 3'b0;
    logic [31:0] i_req_addr = 32'h0;
    logic [31:0] i_req_wdata = 32'h0;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_resp_misaligned;
    logic [31:0] o_mem_addr;
    logic        o_mem_rd_en;
    logic        o_mem_wr_en;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata = 32'h0;

    int vectors = 0;
    int miscompares = 0;
    int rdCount = 0;
    int wrCount = 0;
    int respCount = 0;

    logic [31:0] memArr [0:255] = '{default: 32'h0};
    logic [31:0] refMem [0:255] = '{default: 32'h0};

    lsu dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_req_store       (i_req_store),
        .i_req_funct3      (i_req_funct3),
        .i_req_addr        (i_req_addr),
        .i_req_wdata       (i_req_wdata),
        .o_resp_valid      (o_resp_valid),
        .o_resp_rdata      (o_resp_rdata),
        .o_resp_misaligned (o_resp_misaligned),
        .o_mem_addr        (o_mem_addr),
        .o_mem_rd_en       (o_mem_rd_en),
        .o_mem_wr_en       (o_mem_wr_en),
        .o_mem_wdata       (o_mem_wdata),
        .i_mem_rdata       (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Data memory: write commits on the strobed edge, read data appears the
    // cycle after the read strobe edge.
    always @(posedge i_clk) begin
        if (o_mem_wr_en) memArr[o_mem_addr[9:2]] <= o_mem_wdata;
        if (o_mem_rd_en) i_mem_rdata <= memArr[o_mem_addr[9:2]];
    end

    // Cycle monitors for strobes and response pulses.
    always @(negedge i_clk) begin
        if (o_mem_rd_en)  rdCount   <= rdCount + 1;
        if (o_mem_wr_en)  wrCount   <= wrCount + 1;
        if (o_resp_valid) respCount <= respCount + 1;
    end

    // Reference model: byte-lane arithmetic on a whole word.
    function automatic int sizeBytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic refMis(input logic [2:0] f3, input logic [31:0] addr);
        return TRAP_EN && ((int'(addr[1:0]) % sizeBytes(f3)) != 0);
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [31:0] addr);
        int n;
        int off;
        logic [31:0] v;
        logic [31:0] mask;
        n = sizeBytes(f3);
        off = int'(addr[1:0]) / n * n;
        v = word >> (8 * off);
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] old, input logic [2:0] f3,
                                             input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        int off;
        logic [31:0] mask;
        n = sizeBytes(f3);
        if (n == 4) return wdata;
        off = int'(addr[1:0]) / n * n;
        mask = ((32'd1 << (8 * n)) - 32'd1) << (8 * off);
        return (old & ~mask) | ((wdata << (8 * off)) & mask);
    endfunction

    // Drives one request and reports what the DUT did; the test tasks judge it.
    task automatic runTxn(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic mis,
                          output int rds, output int wrs, output int readyHigh,
                          output logic [31:0] memAddr, output logic pulseLong,
                          output logic timedOut);
        int rd0;
        int wr0;
        int waitCnt;
        timedOut = 1'b0; lat = 0; rdata = 32'h0; mis = 1'b0; rds = 0; wrs = 0;
        readyHigh = 0; memAddr = 32'h0; pulseLong = 1'b0;
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_store = store; i_req_funct3 = f3;
        i_req_addr = addr; i_req_wdata = wdata;
        waitCnt = 0;
        while (!o_req_ready && waitCnt < 20) begin
            @(negedge i_clk);
            waitCnt++;
        end
        if (!o_req_ready) begin
            timedOut = 1'b1;
            i_req_valid = 1'b0;
            return;
        end
        rd0 = rdCount;
        wr0 = wrCount;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_req_store = 1'($urandom); i_req_funct3 = 3'($urandom);
        i_req_addr = $urandom; i_req_wdata = $urandom;
        while (!o_resp_valid && lat < 20) begin
            if (o_req_ready) readyHigh++;
            @(negedge i_clk);
            lat++;
        end
        if (!o_resp_valid) timedOut = 1'b1;
        if (o_req_ready) readyHigh++;
        rdata = o_resp_rdata;
        mis = o_resp_misaligned;
        memAddr = o_mem_addr;
        rds = rdCount - rd0;
        wrs = wrCount - wr0;
        @(negedge i_clk);
        pulseLong = o_resp_valid;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #3;
        vectors++;
        if ({o_req_ready, o_resp_valid, o_resp_misaligned, o_mem_rd_en, o_mem_wr_en} !== 5'b10000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b expected 10000",
                     {o_req_ready, o_resp_valid, o_resp_misaligned, o_mem_rd_en, o_mem_wr_en});
        end
        vectors++;
        if ({o_resp_rdata, o_mem_addr, o_mem_wdata} !== 96'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got rdata=%h addr=%h wdata=%h expected 0",
                     o_resp_rdata, o_mem_addr, o_mem_wdata);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_word();
        int lat; logic [31:0] rdata; logic mis; int rds; int wrs; int rh;
        logic [31:0] ma; logic pl; logic to;
        runTxn(1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, lat, rdata, mis, rds, wrs, rh, ma, pl, to);
        vectors++;
        if ({to, pl, rh[3:0], lat[3:0], rds[3:0], wrs[3:0], rdata} !== {1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd1, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL sw_word: got to=%b pulse=%b rdy=%0d lat=%0d rd=%0d wr=%0d rdata=%h expected 0 0 0 1 0 1 0",
                     to, pl, rh, lat, rds, wrs, rdata);
        end
        runTxn(1'b0, 3'b010, 32'h1000, 32'h0, lat, rdata, mis, rds, wrs, rh, ma, pl, to);
        vectors++;
        if ({to, pl, rh[3:0], lat[3:0], rds[3:0], wrs[3:0], mis} !== {1'b0, 1'b0, 4'd0, 4'd2, 4'd1, 4'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL lw_timing: got to=%b pulse=%b rdy=%0d lat=%0d rd=%0d wr=%0d mis=%b expected 0 0 0 2 1 0 0",
                     to, pl, rh, lat, rds, wrs, mis);
        end
        vectors++;
        if (rdata !== 32'hDEADBEEF || ma !== 32'h1000) begin
            miscompares++;
            $display("[TB] FAIL lw_data: got rdata=%h addr=%h expected deadbeef 00001000", rdata, ma);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [4] = '{32'h1007, 32'h1007, 32'h1006, 32'h1004};
        logic [31:0] exps[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        int lat; logic [31:0] rdata; logic mis; int rds; int wrs; int rh;
        logic [31:0] ma; logic pl; logic to;
        runTxn(1'b1, 3'b010, 32'h1004, 32'h80FF7F01, lat, rdata, mis, rds, wrs, rh, ma, pl, to);
        for (int i = 0; i < 4; i++) begin
            runTxn(1'b0, f3s[i], ads[i], 32'h0, lat, rdata, mis, rds, wrs, rh, ma, pl, to);
            vectors++;
            if (to !== 1'b0 || lat != 2 || rdata !== exps[i] || ma !== 32'h1004) begin
                miscompares++;
                $display("[TB] FAIL load_ext[%0d]: got to=%b lat=%0d rdata=%h addr=%h expected lat=2 rdata=%h addr=00001004",
                         i, to, lat, rdata, ma, exps[i]);
            end
        end
    endtask

    task automatic test_rmw();
        logic [2:0]  f3s [2] = '{3'b000, 3'b001};
        logic [31:0] ads [2] = '{32'h1009, 32'h100A};
        logic [31:0] wds [2] = '{32'hFFFFFFAB, 32'h1234CDEF};
        logic [31:0] exps[2] = '{32'h1122AB44, 32'hCDEFAB44};
        int lat; logic [31:0] rdata; logic mis; int rds; int wrs; int rh;
        logic [31:0] ma; logic pl; logic to;
        runTxn(1'b1, 3'b010, 32'h1008, 32'h11223344, lat, rdata, mis, rds, wrs, rh, ma, pl, to);
        for (int i = 0; i < 2; i++) begin
            runTxn(1'b1, f3s[i], ads[i], wds[i], lat, rdata, mis, rds, wrs, rh, ma, pl, to);
            vectors++;
            if ({to, pl, rh[3:0], lat[3:0], rds[3:0], wrs[3:0], rdata} !== {1'b0, 1'b0, 4'd0, 4'd3, 4'd1, 4'd1, 32'h0}) begin
                miscompares++;
                $display("[TB] FAIL rmw_timing[%0d]: got to=%b pulse=%b rdy=%0d lat=%0d rd=%0d wr=%0d rdata=%h expected 0 0 0 3 1 1 0",
                         i, to, pl, rh, lat, rds, wrs, rdata);
            end
            runTxn(1'b0, 3'b010, 32'h1008, 32'h0, lat, rdata, mis, rds, wrs, rh, ma, pl, to);
            vectors++;
            if (to !== 1'b0 || rdata !== exps[i]) begin
                miscompares++;
                $display("[TB] FAIL rmw_word[%0d]: got to=%b word=%h expected %h", i, to, rdata, exps[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rdata; logic mis; int rds; int wrs; int rh;
        logic [31:0] ma; logic pl; logic to;
        int expLat; int expRds; logic expMis; logic [31:0] expData;
        expLat  = TRAP_EN ? 0 : 2;
        expRds  = TRAP_EN ? 0 : 1;
        expMis  = TRAP_EN;
        expData = TRAP_EN ? 32'h0 : 32'hDEADBEEF;
        runTxn(1'b0, 3'b010, 32'h1002, 32'h0, lat, rdata, mis, rds, wrs, rh, ma, pl, to);
        vectors++;
        if (to !== 1'b0 || pl !== 1'b0 || lat != expLat || rds != expRds || wrs != 0) begin
            miscompares++;
            $display("[TB] FAIL misalign_timing: got to=%b pulse=%b lat=%0d rd=%0d wr=%0d expected 0 0 %0d %0d 0",
                     to, pl, lat, rds, wrs, expLat, expRds);
        end
        vectors++;
        if (mis !== expMis || rdata !== expData || ma !== 32'h1000) begin
            miscompares++;
            $display("[TB] FAIL misalign_resp: got mis=%b rdata=%h addr=%h expected mis=%b rdata=%h addr=00001000",
                     mis, rdata, ma, expMis, expData);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        int readyHigh;
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_store = 1'b0; i_req_funct3 = 3'b010;
        i_req_addr = 32'h1000; i_req_wdata = 32'h0;
        @(posedge i_clk);
        @(negedge i_clk);
        cycles = 0;
        readyHigh = 0;
        while (!o_resp_valid && cycles < 20) begin
            if (o_req_ready) readyHigh++;
            @(negedge i_clk);
            cycles++;
        end
        if (o_req_ready) readyHigh++;
        vectors++;
        if (readyHigh != 0 || cycles != 2 || o_resp_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: got readyHigh=%0d lat=%0d rdata=%h expected 0 2 deadbeef",
                     readyHigh, cycles, o_resp_rdata);
        end
        i_req_funct3 = 3'b101;
        i_req_addr = 32'h1004;
        @(negedge i_clk);
        vectors++;
        if (o_req_ready !== 1'b1 || o_mem_rd_en !== 1'b0 || o_resp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_idle_gap: got ready=%b rd_en=%b resp=%b expected 1 0 0",
                     o_req_ready, o_mem_rd_en, o_resp_valid);
        end
        @(negedge i_clk);
        i_req_valid = 1'b0;
        vectors++;
        if (o_req_ready !== 1'b0 || o_mem_rd_en !== 1'b1 || o_mem_addr !== 32'h1004) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_accept: got ready=%b rd_en=%b addr=%h expected 0 1 00001004",
                     o_req_ready, o_mem_rd_en, o_mem_addr);
        end
        cycles = 0;
        while (!o_resp_valid && cycles < 20) begin
            @(negedge i_clk);
            cycles++;
        end
        vectors++;
        if (o_resp_valid !== 1'b1 || o_resp_rdata !== 32'h00007F01) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_data: got valid=%b rdata=%h expected 1 00007f01",
                     o_resp_valid, o_resp_rdata);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset_midop();
        int respBefore;
        int wrBefore;
        int lat; logic [31:0] rdata; logic mis; int rds; int wrs; int rh;
        logic [31:0] ma; logic pl; logic to;
        // Reset while a load is in READ.
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_store = 1'b0; i_req_funct3 = 3'b010; i_req_addr = 32'h1000;
        @(posedge i_clk);
        #2;
        i_req_valid = 1'b0;
        vectors++;
        if (o_mem_rd_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midop_read_strobe: got %b expected 1", o_mem_rd_en);
        end
        respBefore = respCount;
        i_rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_req_ready, o_resp_valid, o_resp_misaligned, o_mem_rd_en, o_mem_wr_en} !== 5'b10000 ||
            o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0 || o_resp_rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midop_async_reset: got ctrl=%b addr=%h wdata=%h rdata=%h expected 10000 0 0 0",
                     {o_req_ready, o_resp_valid, o_resp_misaligned, o_mem_rd_en, o_mem_wr_en},
                     o_mem_addr, o_mem_wdata, o_resp_rdata);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (6) @(negedge i_clk);
        vectors++;
        if (respCount != respBefore) begin
            miscompares++;
            $display("[TB] FAIL midop_no_resp: got %0d pulses expected 0", respCount - respBefore);
        end
        // Reset while a byte store waits in RWAIT: its write must never happen.
        i_req_valid = 1'b1; i_req_store = 1'b1; i_req_funct3 = 3'b000;
        i_req_addr = 32'h1011; i_req_wdata = 32'h000000A5;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(negedge i_clk);
        wrBefore = wrCount;
        respBefore = respCount;
        #1 i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        runTxn(1'b0, 3'b010, 32'h1010, 32'h0, lat, rdata, mis, rds, wrs, rh, ma, pl, to);
        vectors++;
        if (wrCount != wrBefore || respCount != respBefore + 1 || rdata !== 32'h0 || to !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_rmw_abandon: got writes=%0d pulses=%0d word=%h expected 0 1 00000000",
                     wrCount - wrBefore, respCount - respBefore, rdata);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rdata; logic mis; int rds; int wrs; int rh;
        logic [31:0] ma; logic pl; logic to;
        logic store; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
        int n; logic isMisal; int expLat; int expRds; int expWrs; logic [31:0] expData;
        for (int i = 0; i < 60; i++) begin
            store = 1'($urandom);
            f3    = 3'($urandom);
            addr  = 32'h1040 + 32'($urandom_range(0, 63));
            wdata = $urandom;
            n = sizeBytes(f3);
            isMisal = refMis(f3, addr);
            expLat  = isMisal ? 0 : (!store ? 2 : (n == 4 ? 1 : 3));
            expRds  = (isMisal || (store && n == 4)) ? 0 : 1;
            expWrs  = (!isMisal && store) ? 1 : 0;
            expData = (isMisal || store) ? 32'h0 : refLoad(refMem[addr[9:2]], f3, addr);
            runTxn(store, f3, addr, wdata, lat, rdata, mis, rds, wrs, rh, ma, pl, to);
            if (store && !isMisal) refMem[addr[9:2]] = refStore(refMem[addr[9:2]], f3, addr, wdata);
            vectors++;
            if (to !== 1'b0 || pl !== 1'b0 || rh != 0 || lat != expLat || rds != expRds || wrs != expWrs) begin
                miscompares++;
                $display("[TB] FAIL rand_timing[%0d]: st=%b f3=%b addr=%h got to=%b pulse=%b rdy=%0d lat=%0d rd=%0d wr=%0d expected lat=%0d rd=%0d wr=%0d",
                         i, store, f3, addr, to, pl, rh, lat, rds, wrs, expLat, expRds, expWrs);
            end
            vectors++;
            if (rdata !== expData || mis !== isMisal || ma !== {addr[31:2], 2'b00}) begin
                miscompares++;
                $display("[TB] FAIL rand_resp[%0d]: st=%b f3=%b addr=%h got rdata=%h mis=%b maddr=%h expected %h %b %h",
                         i, store, f3, addr, rdata, mis, ma, expData, isMisal, {addr[31:2], 2'b00});
            end
        end
        // Read back every touched word to confirm the merged stores landed.
        for (int w = 16; w < 32; w++) begin
            runTxn(1'b0, 3'b010, 32'h1000 + 32'(w * 4), 32'h0, lat, rdata, mis, rds, wrs, rh, ma, pl, to);
            vectors++;
            if (to !== 1'b0 || rdata !== refMem[w]) begin
                miscompares++;
                $display("[TB] FAIL rand_readback[%0d]: got %h expected %h", w, rdata, refMem[w]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_loads();
        test_rmw();
        test_misaligned();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
